// File: rtl/correlation_accumulator.sv
// Integrates the signed product of two sample streams over windows delimited by the
// rising edge of window_end, and offers each window's result through a valid/ready register.
module correlation_accumulator #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int RESOLUTION   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_a,
  input  logic [SAMPLE_WIDTH-1:0] sample_b,
  input  logic                    sample_valid,
  input  logic                    window_end,
  output logic [RESOLUTION-1:0]   corr_out,
  output logic [RESOLUTION-1:0]   count_out,
  output logic                    saturated_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    dropped
);

  localparam int PW = 2 * SAMPLE_WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [RESOLUTION-1:0]   acc_reg;
  logic [RESOLUTION-1:0]   count_reg;
  logic                    sat_reg;
  logic                    window_end_q;

  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic signed [PW-1:0]    product;
  logic [RESOLUTION-1:0]   product_ext;
  logic [RESOLUTION-1:0]   addend;
  logic [RESOLUTION:0]     sum_wide;
  logic                    sum_overflow;
  logic [RESOLUTION-1:0]   sum_sat;
  logic                    count_inc;
  logic [RESOLUTION-1:0]   count_next;
  logic                    win_edge;
  logic                    transfer;
  logic                    load_ok;

  localparam logic [RESOLUTION-1:0] ACC_MAX = {1'b0, {(RESOLUTION-1){1'b1}}};
  localparam logic [RESOLUTION-1:0] ACC_MIN = {1'b1, {(RESOLUTION-1){1'b0}}};

  // Operands are widened first so the multiply yields the full-width signed product.
  assign a_ext   = {{SAMPLE_WIDTH{sample_a[SAMPLE_WIDTH-1]}}, sample_a};
  assign b_ext   = {{SAMPLE_WIDTH{sample_b[SAMPLE_WIDTH-1]}}, sample_b};
  assign product = a_ext * b_ext;

  generate
    if (RESOLUTION > PW) begin : g_ext
      assign product_ext = {{(RESOLUTION-PW){product[PW-1]}}, product};
    end else begin : g_noext
      assign product_ext = product;
    end
  endgenerate

  assign addend = sample_valid ? product_ext : '0;

  // One guard bit catches two's-complement overflow; clip to the signed range.
  assign sum_wide     = {acc_reg[RESOLUTION-1], acc_reg} + {addend[RESOLUTION-1], addend};
  assign sum_overflow = sum_wide[RESOLUTION] ^ sum_wide[RESOLUTION-1];
  assign sum_sat      = sum_overflow ? (sum_wide[RESOLUTION] ? ACC_MIN : ACC_MAX)
                                     : sum_wide[RESOLUTION-1:0];

  assign count_inc  = sample_valid & ~(&count_reg);
  assign count_next = count_reg + {{(RESOLUTION-1){1'b0}}, count_inc};

  assign win_edge = window_end & ~window_end_q;
  assign transfer = out_valid & out_ready;
  assign load_ok  = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      sat_reg       <= 1'b0;
      window_end_q  <= 1'b0;
      corr_out      <= '0;
      count_out     <= '0;
      saturated_out <= 1'b0;
      out_valid     <= 1'b0;
      dropped       <= 1'b0;
    end else begin
      window_end_q <= window_end;

      // A load below overrides this clear when both happen in one cycle.
      if (transfer) begin
        out_valid <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          acc_reg   <= '0;
          count_reg <= '0;
          sat_reg   <= 1'b0;
          if (enable) begin
            state_reg <= RUN;
          end
        end

        RUN: begin
          if (!enable) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
          end else if (win_edge) begin
            acc_reg   <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
            if (load_ok) begin
              corr_out      <= sum_sat;
              count_out     <= count_next;
              saturated_out <= sat_reg | sum_overflow;
              out_valid     <= 1'b1;
            end else begin
              dropped <= 1'b1;
            end
          end else begin
            acc_reg   <= sum_sat;
            count_reg <= count_next;
            sat_reg   <= sat_reg | sum_overflow;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_correlation_accumulator.sv
// Directed bench for correlation_accumulator: two instances (64-bit and 16-bit results)
// are checked every cycle against a window-level model, with literal pins on key results.
module tb_correlation_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  sample_a;
  logic [7:0]  sample_b;
  logic        sample_valid;
  logic        window_end;
  logic        out_ready;

  logic [63:0] corr64, count64;
  logic        sat64, valid64, drop64;
  logic [15:0] corr16, count16;
  logic        sat16, valid16, drop16;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  correlation_accumulator #(.SAMPLE_WIDTH(8), .RESOLUTION(64)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_a(sample_a), .sample_b(sample_b), .sample_valid(sample_valid),
    .window_end(window_end),
    .corr_out(corr64), .count_out(count64), .saturated_out(sat64),
    .out_valid(valid64), .out_ready(out_ready), .dropped(drop64)
  );

  correlation_accumulator #(.SAMPLE_WIDTH(8), .RESOLUTION(16)) dut16 (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_a(sample_a), .sample_b(sample_b), .sample_valid(sample_valid),
    .window_end(window_end),
    .corr_out(corr16), .count_out(count16), .saturated_out(sat16),
    .out_valid(valid16), .out_ready(out_ready), .dropped(drop16)
  );

  // Model: index 0 = 64-bit instance, 1 = 16-bit instance.
  int                 res_w [2] = '{64, 16};
  bit                 m_run [2];
  logic signed [71:0] m_acc [2];
  logic signed [71:0] m_cnt [2];
  bit                 m_sat [2];
  logic signed [71:0] m_corr [2];
  logic signed [71:0] m_count [2];
  bit                 m_osat [2];
  bit                 m_ov [2];
  bit                 m_drop [2];
  bit                 m_prev_we;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    bit edge_now;
    edge_now = window_end && !m_prev_we;
    m_prev_we = reset ? window_end : 1'b0;
    for (int k = 0; k < 2; k++) begin
      logic signed [71:0] lim, prod, s, c;
      bit ov_before, over;
      if (!reset) begin
        m_run[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
        m_corr[k] = 0; m_count[k] = 0; m_osat[k] = 0; m_ov[k] = 0; m_drop[k] = 0;
      end else begin
        ov_before = m_ov[k];
        if (m_ov[k] && out_ready) m_ov[k] = 0;
        lim = 72'sd1 <<< (res_w[k] - 1);
        if (!m_run[k]) begin
          m_run[k] = enable;
        end else if (!enable) begin
          m_run[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
        end else begin
          prod = sample_valid ? (longint'($signed(sample_a)) * longint'($signed(sample_b))) : 72'sd0;
          s = m_acc[k] + prod;
          over = 0;
          if (s > lim - 1) begin s = lim - 1; over = 1; end
          if (s < -lim)    begin s = -lim;    over = 1; end
          c = m_cnt[k] + (sample_valid ? 1 : 0);
          if (c > (72'sd1 <<< res_w[k]) - 1) c = (72'sd1 <<< res_w[k]) - 1;
          if (edge_now) begin
            if (!ov_before || out_ready) begin
              m_corr[k] = s; m_count[k] = c; m_osat[k] = m_sat[k] || over; m_ov[k] = 1;
            end else begin
              m_drop[k] = 1;
            end
            m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
          end else begin
            m_acc[k] = s; m_cnt[k] = c; m_sat[k] = m_sat[k] || over;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("corr64",  corr64,  m_corr[0][63:0]);
      chk("count64", count64, m_count[0][63:0]);
      chk("sat64",   {63'b0, sat64},   {63'b0, m_osat[0]});
      chk("valid64", {63'b0, valid64}, {63'b0, m_ov[0]});
      chk("drop64",  {63'b0, drop64},  {63'b0, m_drop[0]});
      chk("corr16",  {48'b0, corr16},  {48'b0, m_corr[1][15:0]});
      chk("count16", {48'b0, count16}, {48'b0, m_count[1][15:0]});
      chk("sat16",   {63'b0, sat16},   {63'b0, m_osat[1]});
      chk("valid16", {63'b0, valid16}, {63'b0, m_ov[1]});
      chk("drop16",  {63'b0, drop16},  {63'b0, m_drop[1]});
    end
  end

  task automatic cyc(input logic en, input logic v, input int a, input int b,
                     input logic we, input logic rdy);
    enable = en; sample_valid = v; sample_a = 8'(a); sample_b = 8'(b);
    window_end = we; out_ready = rdy;
    @(posedge clk);
    #1;
    $display("cyc en=%0b v=%0b a=%0d b=%0d we=%0b rdy=%0b -> corr=%0d cnt=%0d ov=%0b drop=%0b",
             en, v, a, b, we, rdy, $signed(corr64), count64, valid64, drop64);
  endtask

  initial begin
    int pulses;
    reset = 1'b0; enable = 1'b0; sample_a = '0; sample_b = '0;
    sample_valid = 1'b0; window_end = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    chk("rst_corr", corr64, 64'd0);
    chk("rst_valid", {63'b0, valid64}, 64'd0);
    reset = 1'b1;

    // Basic window: 10 x (3 * -2), edge on the 10th sample
    cyc(1, 0, 0, 0, 0, 0);
    repeat (9) cyc(1, 1, 3, -2, 0, 0);
    cyc(1, 1, 3, -2, 1, 0);
    chk("t1_corr", corr64, -64'sd60);
    chk("t1_count", count64, 64'd10);
    chk("t1_valid", {63'b0, valid64}, 64'd1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("t1_consumed", {63'b0, valid64}, 64'd0);

    // Level held high: one result, next window counts from cycle after the edge
    pulses = 0;
    cyc(1, 1, 1, 1, 1, 1); if (valid64) pulses++;
    repeat (4) begin cyc(1, 1, 1, 1, 1, 1); if (valid64) pulses++; end
    repeat (3) begin cyc(1, 1, 1, 1, 0, 1); if (valid64) pulses++; end
    chk("t2_one_pulse", 64'(pulses), 64'd1);
    cyc(1, 1, 1, 1, 1, 1);
    chk("t2_corr", corr64, 64'd8);
    chk("t2_count", count64, 64'd8);
    cyc(1, 0, 0, 0, 0, 1);

    // Backpressure: first result held, second dropped
    repeat (3) cyc(1, 1, 2, 2, 0, 0);
    cyc(1, 1, 2, 2, 1, 0);
    chk("t3_corr", corr64, 64'd16);
    repeat (3) begin cyc(1, 1, 1, 1, 0, 0); chk("t3_hold", corr64, 64'd16); end
    cyc(1, 1, 1, 1, 1, 0);
    chk("t3_keep", corr64, 64'd16);
    chk("t3_count", count64, 64'd4);
    chk("t3_drop", {63'b0, drop64}, 64'd1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("t3_xfer", {63'b0, valid64}, 64'd0);
    chk("t3_sticky", {63'b0, drop64}, 64'd1);

    // Reset mid-window with a pending result
    cyc(1, 1, 3, 3, 0, 0);
    cyc(1, 1, 3, 3, 1, 0);
    chk("t6_corr", corr64, 64'd18);
    repeat (2) cyc(1, 1, 3, 3, 0, 0);
    reset = 1'b0;
    cyc(1, 1, 3, 3, 0, 0);
    chk("t6_corr0", corr64, 64'd0);
    chk("t6_valid0", {63'b0, valid64}, 64'd0);
    chk("t6_drop0", {63'b0, drop64}, 64'd0);
    reset = 1'b1;

    // Close while the old result transfers in the same cycle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 1, 0, 0);
    cyc(1, 1, 5, 1, 1, 0);
    chk("t5_first", corr64, 64'd10);
    cyc(1, 1, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 1, 1);
    chk("t5_corr", corr64, 64'd2);
    chk("t5_valid", {63'b0, valid64}, 64'd1);
    chk("t5_drop", {63'b0, drop64}, 64'd0);
    cyc(1, 0, 0, 0, 0, 1);

    // Saturation on the 16-bit instance
    repeat (2) cyc(1, 1, 127, 127, 0, 1);
    cyc(1, 1, 127, 127, 1, 1);
    chk("t4_corr16", {48'b0, corr16}, 64'h7FFF);
    chk("t4_count16", {48'b0, count16}, 64'd3);
    chk("t4_sat16", {63'b0, sat16}, 64'd1);
    chk("t4_corr64", corr64, 64'd48387);
    chk("t4_sat64", {63'b0, sat64}, 64'd0);
    cyc(1, 1, 1, 1, 0, 1);
    cyc(1, 1, 1, 1, 1, 1);
    chk("t4_corr16b", {48'b0, corr16}, 64'd2);
    chk("t4_sat16b", {63'b0, sat16}, 64'd0);

    // Enable dropped mid-window: only post-enable samples count
    repeat (3) cyc(1, 1, 1, 1, 0, 1);
    repeat (2) cyc(0, 1, 1, 1, 0, 1);
    cyc(1, 1, 1, 1, 0, 1);
    repeat (3) cyc(1, 1, 1, 1, 0, 1);
    cyc(1, 1, 1, 1, 1, 1);
    chk("t7_corr", corr64, 64'd4);
    chk("t7_count", count64, 64'd4);

    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
